// File: rtl/wired_lsu_sb_drain_if.sv
// Store-buffer drain bundle: SB top-entry view,
// dcache SRAM write port, refill port and uncached bus port.
interface wired_lsu_sb_drain_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAYS   = 2
) ();
  localparam int STRB_W = DATA_W / 8;

  logic              flush_i;
  logic              top_valid_i;
  logic [WAYS-1:0]   top_hit_i;
  logic              top_uncached_i;
  logic [ADDR_W-1:0] top_addr_i;
  logic [DATA_W-1:0] top_data_i;
  logic [STRB_W-1:0] top_strb_i;
  logic              pop_o;
  logic              sram_wreq_o;
  logic              sram_wready_i;
  logic [WAYS-1:0]   sram_way_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [DATA_W-1:0] sram_data_o;
  logic [STRB_W-1:0] sram_strb_o;
  logic              refill_req_o;
  logic              refill_ready_i;
  logic              refill_done_i;
  logic              bus_req_o;
  logic              bus_ready_i;
  logic              bus_resp_i;
  logic              busy_o;
  logic [31:0]       drain_cnt_o;

  modport slave (
    input  flush_i, top_valid_i, top_hit_i,
    input  top_uncached_i, top_addr_i,
    input  top_data_i, top_strb_i,
    input  sram_wready_i, refill_ready_i,
    input  refill_done_i, bus_ready_i,
    input  bus_resp_i,
    output pop_o, sram_wreq_o, sram_way_o,
    output sram_addr_o, sram_data_o,
    output sram_strb_o, refill_req_o,
    output bus_req_o, busy_o, drain_cnt_o
  );

  modport master (
    output flush_i, top_valid_i, top_hit_i,
    output top_uncached_i, top_addr_i,
    output top_data_i, top_strb_i,
    output sram_wready_i, refill_ready_i,
    output refill_done_i, bus_ready_i,
    output bus_resp_i,
    input  pop_o, sram_wreq_o, sram_way_o,
    input  sram_addr_o, sram_data_o,
    input  sram_strb_o, refill_req_o,
    input  bus_req_o, busy_o, drain_cnt_o
  );
endinterface

// File: rtl/wired_lsu_sb_drain.sv
// Store-buffer drain: retires the committed top entry
// as an SRAM write, a refill-then-write, or a bus write.
module wired_lsu_sb_drain #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAYS   = 2
) (
  input logic clk,
  input logic rst_n,
  wired_lsu_sb_drain_if.slave sb
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_MREQ,
    S_MWAIT,
    S_UREQ,
    S_UWAIT
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [STRB_W-1:0] r_strb;
  logic [WAYS-1:0]   r_way;
  logic [WAYS-1:0]   w_way;
  logic              r_wreq;
  logic              r_rreq;
  logic              r_breq;
  logic              r_fp;
  logic              w_fp;
  logic              w_ld;
  logic              w_pop;
  logic [31:0]       r_cnt;

  assign w_way = sb.top_hit_i
               & (~sb.top_hit_i + WAYS'(1));

  // Next state, pop and flush-pending decode.
  always_comb begin
    w_nxt = r_state;
    w_ld  = 1'b0;
    w_pop = 1'b0;
    w_fp  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (sb.top_valid_i && !sb.flush_i) begin
          w_ld = 1'b1;
          if (sb.top_uncached_i)
            w_nxt = S_UREQ;
          else if (|sb.top_hit_i)
            w_nxt = S_WRITE;
          else
            w_nxt = S_MREQ;
        end
      end
      S_WRITE: begin
        if (sb.sram_wready_i) begin
          w_pop = 1'b1;
          w_nxt = S_IDLE;
        end else if (sb.flush_i) begin
          w_nxt = S_IDLE;
        end
      end
      S_MREQ: begin
        if (sb.refill_ready_i)
          w_nxt = S_MWAIT;
        else if (sb.flush_i)
          w_nxt = S_IDLE;
      end
      S_MWAIT: begin
        w_fp = r_fp | sb.flush_i;
        if (sb.refill_done_i) begin
          w_fp  = 1'b0;
          w_nxt = S_IDLE;
        end
      end
      S_UREQ: begin
        if (sb.bus_ready_i)
          w_nxt = S_UWAIT;
        else if (sb.flush_i)
          w_nxt = S_IDLE;
      end
      S_UWAIT: begin
        w_fp = r_fp | sb.flush_i;
        if (sb.bus_resp_i) begin
          w_pop = !(r_fp || sb.flush_i);
          w_fp  = 1'b0;
          w_nxt = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // State, registered requests and flush-pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wreq  <= 1'b0;
      r_rreq  <= 1'b0;
      r_breq  <= 1'b0;
      r_fp    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_wreq  <= (w_nxt == S_WRITE);
      r_rreq  <= (w_nxt == S_MREQ);
      r_breq  <= (w_nxt == S_UREQ);
      r_fp    <= w_fp;
    end
  end

  // Holding register for the entry being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_data <= '0;
      r_strb <= '0;
      r_way  <= '0;
    end else if (w_ld) begin
      r_addr <= sb.top_addr_i;
      r_data <= sb.top_data_i;
      r_strb <= sb.top_strb_i;
      r_way  <= w_way;
    end
  end

  // Retired-entry counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_pop)
      r_cnt <= r_cnt + 32'd1;
  end

  assign sb.pop_o        = w_pop;
  assign sb.sram_wreq_o  = r_wreq;
  assign sb.refill_req_o = r_rreq;
  assign sb.bus_req_o    = r_breq;
  assign sb.sram_way_o   = r_way;
  assign sb.sram_addr_o  = r_addr;
  assign sb.sram_data_o  = r_data;
  assign sb.sram_strb_o  = r_strb;
  assign sb.busy_o       = (r_state != S_IDLE);
  assign sb.drain_cnt_o  = r_cnt;
endmodule

// File: tb/tb_wired_lsu_sb_drain.sv
// Self-checking bench for the store-buffer drain:
// scoreboard of expected pops plus directed sequences.
module tb_wired_lsu_sb_drain;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  wired_lsu_sb_drain_if #(
    .ADDR_W(32), .DATA_W(32), .WAYS(2)
  ) u_if ();

  wired_lsu_sb_drain #(
    .ADDR_W(32), .DATA_W(32), .WAYS(2)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sb   (u_if.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  typedef struct {
    logic [1:0]  hit;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  way;
  } vec_t;

  exp_t  q[$];
  vec_t  tv[4];
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_wr  = 0;
  int    exp_cnt = 0;
  int    wr0;
  time   t_prev;
  time   t_now;

  task automatic chk(string nm,
                     logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_top(logic [1:0] hit,
                           logic unc,
                           logic [31:0] addr,
                           logic [31:0] data,
                           logic [3:0] strb);
    u_if.top_valid_i    = 1'b1;
    u_if.top_hit_i      = hit;
    u_if.top_uncached_i = unc;
    u_if.top_addr_i     = addr;
    u_if.top_data_i     = data;
    u_if.top_strb_i     = strb;
  endtask

  task automatic expect_pop(logic [31:0] addr,
                            logic [31:0] data,
                            logic [3:0] strb);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.strb = strb;
    q.push_back(e);
    exp_cnt++;
  endtask

  task automatic idle_top();
    u_if.top_valid_i    = 1'b0;
    u_if.top_uncached_i = 1'b0;
    u_if.top_hit_i      = 2'b00;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.sram_wreq_o && u_if.sram_wready_i)
        n_wr++;
      if (u_if.top_valid_i &&
          $countones(u_if.top_hit_i) > 1)
        $display("NOTE: multiple hit bits %b",
                 u_if.top_hit_i);
      if (u_if.pop_o) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_pop", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_addr", u_if.sram_addr_o, e.addr);
          chk("sb_data", u_if.sram_data_o, e.data);
          chk("sb_strb", u_if.sram_strb_o, e.strb);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.flush_i        = 1'b0;
    u_if.top_valid_i    = 1'b0;
    u_if.top_hit_i      = '0;
    u_if.top_uncached_i = 1'b0;
    u_if.top_addr_i     = '0;
    u_if.top_data_i     = '0;
    u_if.top_strb_i     = '0;
    u_if.sram_wready_i  = 1'b0;
    u_if.refill_ready_i = 1'b0;
    u_if.refill_done_i  = 1'b0;
    u_if.bus_ready_i    = 1'b0;
    u_if.bus_resp_i     = 1'b0;

    tv[0] = '{2'b01, 32'h1000, 32'h11111111, 4'hF, 2'b01};
    tv[1] = '{2'b10, 32'h1004, 32'h22222222, 4'h3, 2'b10};
    tv[2] = '{2'b11, 32'h1008, 32'h33333333, 4'hC, 2'b01};
    tv[3] = '{2'b10, 32'h100C, 32'h44444444, 4'h1, 2'b10};

    repeat (2) @(posedge clk);
    mid();
    chk("rst_pop",  u_if.pop_o, 0);
    chk("rst_wreq", u_if.sram_wreq_o, 0);
    chk("rst_rreq", u_if.refill_req_o, 0);
    chk("rst_breq", u_if.bus_req_o, 0);
    chk("rst_busy", u_if.busy_o, 0);
    chk("rst_cnt",  u_if.drain_cnt_o, 0);
    chk("rst_addr", u_if.sram_addr_o, 0);
    chk("rst_way",  u_if.sram_way_o, 0);
    nxt();
    rst_n = 1'b1;

    // hit store, wready two cycles after request
    nxt();
    drive_top(2'b10, 0, 32'h100, 32'hDEADBEEF, 4'hF);
    expect_pop(32'h100, 32'hDEADBEEF, 4'hF);
    mid();
    chk("a_idle_wreq", u_if.sram_wreq_o, 0);
    nxt();
    u_if.top_data_i = 32'h0;
    mid();
    chk("a_wreq", u_if.sram_wreq_o, 1);
    chk("a_way",  u_if.sram_way_o, 2'b10);
    chk("a_addr", u_if.sram_addr_o, 32'h100);
    chk("a_data", u_if.sram_data_o, 32'hDEADBEEF);
    chk("a_pop0", u_if.pop_o, 0);
    nxt();
    mid();
    chk("a_hold_wreq", u_if.sram_wreq_o, 1);
    chk("a_hold_data", u_if.sram_data_o, 32'hDEADBEEF);
    chk("a_pop1", u_if.pop_o, 0);
    nxt();
    u_if.sram_wready_i = 1'b1;
    mid();
    chk("a_pop", u_if.pop_o, 1);
    nxt();
    u_if.sram_wready_i = 1'b0;
    idle_top();
    mid();
    chk("a_busy", u_if.busy_o, 0);
    chk("a_wreq_off", u_if.sram_wreq_o, 0);
    chk("a_cnt", u_if.drain_cnt_o, exp_cnt);

    // miss store: refill, then re-check hit
    nxt();
    drive_top(2'b00, 0, 32'h200, 32'h12345678, 4'h3);
    expect_pop(32'h200, 32'h12345678, 4'h3);
    nxt();
    u_if.refill_ready_i = 1'b1;
    mid();
    chk("b_rreq", u_if.refill_req_o, 1);
    chk("b_wreq", u_if.sram_wreq_o, 0);
    chk("b_addr", u_if.sram_addr_o, 32'h200);
    nxt();
    u_if.refill_ready_i = 1'b0;
    mid();
    chk("b_rreq_off", u_if.refill_req_o, 0);
    chk("b_wait_busy", u_if.busy_o, 1);
    nxt();
    nxt();
    nxt();
    u_if.refill_done_i = 1'b1;
    u_if.top_hit_i     = 2'b01;
    mid();
    chk("b_done_pop", u_if.pop_o, 0);
    nxt();
    u_if.refill_done_i = 1'b0;
    mid();
    chk("b_idle_busy", u_if.busy_o, 0);
    nxt();
    u_if.sram_wready_i = 1'b1;
    mid();
    chk("b_wreq_hit", u_if.sram_wreq_o, 1);
    chk("b_way", u_if.sram_way_o, 2'b01);
    chk("b_pop", u_if.pop_o, 1);
    nxt();
    u_if.sram_wready_i = 1'b0;
    idle_top();
    mid();
    chk("b_cnt", u_if.drain_cnt_o, exp_cnt);

    // uncached store with a hit: bus path wins
    wr0 = n_wr;
    nxt();
    drive_top(2'b01, 1, 32'h300, 32'hCAFEF00D, 4'hC);
    expect_pop(32'h300, 32'hCAFEF00D, 4'hC);
    nxt();
    mid();
    chk("c_breq", u_if.bus_req_o, 1);
    chk("c_wreq", u_if.sram_wreq_o, 0);
    chk("c_rreq", u_if.refill_req_o, 0);
    nxt();
    u_if.bus_ready_i = 1'b1;
    mid();
    chk("c_breq_hold", u_if.bus_req_o, 1);
    nxt();
    u_if.bus_ready_i = 1'b0;
    mid();
    chk("c_breq_off", u_if.bus_req_o, 0);
    chk("c_busy", u_if.busy_o, 1);
    nxt();
    nxt();
    nxt();
    u_if.bus_resp_i = 1'b1;
    mid();
    chk("c_pop", u_if.pop_o, 1);
    nxt();
    u_if.bus_resp_i = 1'b0;
    idle_top();
    mid();
    chk("c_busy_off", u_if.busy_o, 0);
    chk("c_cnt", u_if.drain_cnt_o, exp_cnt);
    chk("c_no_sram", n_wr - wr0, 0);

    // flush while waiting for the bus response
    nxt();
    drive_top(2'b00, 1, 32'h400, 32'h55AA55AA, 4'hF);
    nxt();
    u_if.bus_ready_i = 1'b1;
    nxt();
    u_if.bus_ready_i = 1'b0;
    mid();
    chk("d_wait_busy", u_if.busy_o, 1);
    nxt();
    u_if.flush_i = 1'b1;
    idle_top();
    mid();
    chk("d_flush_pop", u_if.pop_o, 0);
    nxt();
    u_if.flush_i = 1'b0;
    mid();
    chk("d_pend_busy", u_if.busy_o, 1);
    nxt();
    nxt();
    u_if.bus_resp_i = 1'b1;
    mid();
    chk("d_resp_pop", u_if.pop_o, 0);
    chk("d_resp_busy", u_if.busy_o, 1);
    nxt();
    u_if.bus_resp_i = 1'b0;
    mid();
    chk("d_busy_fall", u_if.busy_o, 0);
    chk("d_cnt", u_if.drain_cnt_o, exp_cnt);

    // flush in WRITE without accept drops it
    nxt();
    drive_top(2'b01, 0, 32'h500, 32'hBAD0BAD0, 4'hF);
    nxt();
    u_if.flush_i = 1'b1;
    idle_top();
    mid();
    chk("f_pop", u_if.pop_o, 0);
    nxt();
    u_if.flush_i = 1'b0;
    mid();
    chk("f_busy", u_if.busy_o, 0);
    chk("f_wreq", u_if.sram_wreq_o, 0);

    // flush coinciding with accept: accept wins
    nxt();
    drive_top(2'b10, 0, 32'h600, 32'h600DF00D, 4'h1);
    expect_pop(32'h600, 32'h600DF00D, 4'h1);
    nxt();
    u_if.flush_i = 1'b1;
    u_if.sram_wready_i = 1'b1;
    mid();
    chk("g_pop", u_if.pop_o, 1);
    nxt();
    u_if.flush_i = 1'b0;
    u_if.sram_wready_i = 1'b0;
    idle_top();
    mid();
    chk("g_busy", u_if.busy_o, 0);
    chk("g_cnt", u_if.drain_cnt_o, exp_cnt);

    // flush in IDLE blocks the start
    nxt();
    drive_top(2'b01, 0, 32'h680, 32'h0, 4'hF);
    u_if.flush_i = 1'b1;
    nxt();
    u_if.flush_i = 1'b0;
    idle_top();
    mid();
    chk("h_busy", u_if.busy_o, 0);
    chk("h_wreq", u_if.sram_wreq_o, 0);

    // back-to-back hits, wready held high
    u_if.sram_wready_i = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      drive_top(tv[i].hit, 0, tv[i].addr,
                tv[i].data, tv[i].strb);
      expect_pop(tv[i].addr, tv[i].data, tv[i].strb);
      mid();
      chk("e_idle_pop", u_if.pop_o, 0);
      nxt();
      mid();
      chk("e_wreq", u_if.sram_wreq_o, 1);
      chk("e_way", u_if.sram_way_o, tv[i].way);
      chk("e_pop", u_if.pop_o, 1);
      t_now = $time;
      if (i > 0)
        chk("e_gap", t_now - t_prev, 20);
      t_prev = t_now;
    end
    nxt();
    u_if.sram_wready_i = 1'b0;
    idle_top();
    mid();
    chk("e_cnt", u_if.drain_cnt_o, exp_cnt);
    chk("e_busy", u_if.busy_o, 0);

    // async reset while in MISS_WAIT
    nxt();
    drive_top(2'b00, 0, 32'h700, 32'h77777777, 4'hF);
    nxt();
    u_if.refill_ready_i = 1'b1;
    nxt();
    u_if.refill_ready_i = 1'b0;
    mid();
    chk("r_pre_busy", u_if.busy_o, 1);
    #1 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("r_busy", u_if.busy_o, 0);
    chk("r_rreq", u_if.refill_req_o, 0);
    chk("r_cnt", u_if.drain_cnt_o, exp_cnt);
    chk("r_addr", u_if.sram_addr_o, 0);
    chk("r_pop", u_if.pop_o, 0);
    idle_top();
    nxt();
    rst_n = 1'b1;
    nxt();
    u_if.refill_done_i = 1'b1;
    mid();
    chk("r_ign_pop", u_if.pop_o, 0);
    nxt();
    u_if.refill_done_i = 1'b0;
    mid();
    chk("r_ign_busy", u_if.busy_o, 0);
    chk("r_ign_wreq", u_if.sram_wreq_o, 0);
    chk("r_ign_cnt", u_if.drain_cnt_o, exp_cnt);

    chk("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
